// File: rtl/sar_search_pkg.sv
// sar_search_pkg: shared types and defaults for the successive-approximation search engine.
//   sar_state_t   : search controller states (IDLE, SEARCH, DONE)
//   SAR_W_DEFAULT : default search width in bits
package sar_search_pkg;

  localparam int unsigned SAR_W_DEFAULT = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SEARCH = 2'd1,
    DONE   = 2'd2
  } sar_state_t;

endpackage

// File: rtl/comparator_8bit.sv
// comparator_8bit: unsigned 8-bit magnitude comparator, the closed-loop partner of the
// SAR search engine.
//   a  : value under test
//   b  : reference / trial value
//   gt : a > b
//   eq : a == b
//   lt : a < b
module comparator_8bit (
  input  logic [7:0] a,
  input  logic [7:0] b,
  output logic       gt,
  output logic       eq,
  output logic       lt
);

  always_comb begin
    gt = (a > b);
    eq = (a == b);
    lt = (a < b);
  end

endmodule

// File: rtl/sar_search_8bit.sv
// sar_search_8bit: successive-approximation search engine. Recovers an unknown value A held
// behind an external magnitude comparator by driving trial values on its B input, one bit
// per cycle, MSB first.
//   clk     : rising-edge clock
//   rst     : asynchronous active-high reset
//   start   : request a search (only sampled while busy=0)
//   cmp_gt  : comparator flag A > trial
//   cmp_eq  : comparator flag A == trial
//   cmp_lt  : comparator flag A < trial
//   trial   : registered candidate driven to comparator B
//   busy    : search in progress
//   done    : one-cycle pulse, result/err valid from this cycle
//   result  : recovered value, held until the next accepted start
//   err     : last search aborted on non-one-hot flags, held until the next accepted start
// Build option: define SAR_SEARCH_EARLY_EXIT_EN to end a search as soon as cmp_eq is seen.
module sar_search_8bit
  import sar_search_pkg::*;
#(
  parameter int unsigned W = SAR_W_DEFAULT
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         cmp_gt,
  input  logic         cmp_eq,
  input  logic         cmp_lt,
  output logic [W-1:0] trial,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] result,
  output logic         err
);

  localparam int unsigned IdxW    = (W > 1) ? $clog2(W) : 1;
  localparam logic [W-1:0] OneLsb = {{(W-1){1'b0}}, 1'b1};
  localparam logic [W-1:0] OneMsb = {1'b1, {(W-1){1'b0}}};

  sar_state_t      state_q, state_d;
  logic [W-1:0]    trial_q, trial_d;
  logic [W-1:0]    result_q, result_d;
  logic [IdxW-1:0] idx_q, idx_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            err_q, err_d;

  logic [W-1:0]    cur_bit;
  logic [W-1:0]    kept;
  logic            flags_valid;

  always_comb begin
    cur_bit     = OneLsb << idx_q;
    // A below the trial means the bit under test overshoots and must be dropped.
    kept        = cmp_lt ? (trial_q & ~cur_bit) : trial_q;
    flags_valid = ({cmp_gt, cmp_eq, cmp_lt} == 3'b100) ||
                  ({cmp_gt, cmp_eq, cmp_lt} == 3'b010) ||
                  ({cmp_gt, cmp_eq, cmp_lt} == 3'b001);

    state_d  = state_q;
    trial_d  = trial_q;
    result_d = result_q;
    idx_d    = idx_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    err_d    = err_q;

    unique case (state_q)
      IDLE, DONE: begin
        state_d = IDLE;
        busy_d  = 1'b0;
        trial_d = '0;
        if (start) begin
          state_d  = SEARCH;
          busy_d   = 1'b1;
          trial_d  = OneMsb;
          idx_d    = IdxW'(W - 1);
          result_d = '0;
          err_d    = 1'b0;
        end
      end

      SEARCH: begin
        if (!flags_valid) begin
          state_d  = DONE;
          busy_d   = 1'b0;
          done_d   = 1'b1;
          trial_d  = '0;
          result_d = '0;
          err_d    = 1'b1;
`ifdef SAR_SEARCH_EARLY_EXIT_EN
        end else if (cmp_eq) begin
          state_d  = DONE;
          busy_d   = 1'b0;
          done_d   = 1'b1;
          trial_d  = '0;
          result_d = trial_q;
`endif
        end else if (idx_q == '0) begin
          state_d  = DONE;
          busy_d   = 1'b0;
          done_d   = 1'b1;
          trial_d  = '0;
          result_d = kept;
        end else begin
          trial_d = kept | (cur_bit >> 1);
          idx_d   = idx_q - IdxW'(1);
        end
      end

      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
        trial_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      trial_q  <= '0;
      result_q <= '0;
      idx_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      trial_q  <= trial_d;
      result_q <= result_d;
      idx_q    <= idx_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

  assign trial  = trial_q;
  assign busy   = busy_q;
  assign done   = done_q;
  assign result = result_q;
  assign err    = err_q;

endmodule
